// File: rtl/uart_rx_control.sv
// uart_rx_control
//   UART receive engine. Recovers frames from the serial line produced by the
//   matching transmit controller and holds one received byte for the host.
//   The host consumes the byte with a one-cycle read strobe.
//
// Ports
//   clk_in          system clock
//   reset_in        synchronous, active-high reset
//   enable_in       receiver enable; low forces the engine back to IDLE
//   rx_in           asynchronous serial line, idle high
//   clk_div_baud_in clock cycles per bit (clamped to a minimum of 4)
//   d_num_in        0 = 8 data bits, 1 = 7 data bits
//   parity_in       00/11 none, 01 odd, 10 even
//   s_num_in        0 = 1 stop bit, 1 = 2 stop bits
//   rd_in           read strobe: clears the held byte's ready and flags
//   data_out        held byte (bit 7 = 0 in 7-bit mode)
//   rx_rdy_out      an unread byte is held
//   parity_err_out  parity mismatch on the held byte
//   frame_err_out   a stop bit of the held byte was sampled low
//   overrun_out     sticky: a frame arrived while a byte was still unread
module uart_rx_control #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        enable_in,
  input  logic        rx_in,
  input  logic [31:0] clk_div_baud_in,
  input  logic        d_num_in,
  input  logic [1:0]  parity_in,
  input  logic        s_num_in,
  input  logic        rd_in,
  output logic [7:0]  data_out,
  output logic        rx_rdy_out,
  output logic        parity_err_out,
  output logic        frame_err_out,
  output logic        overrun_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity error for a received word: odd mode wants an odd total count of
  // ones over data plus parity bit, even mode an even count.
  function automatic logic parity_error(input logic [7:0] data,
                                        input logic       pbit,
                                        input logic [1:0] mode);
    logic sum;
    sum = (^data) ^ pbit;
    case (mode)
      2'b01:   parity_error = ~sum;
      2'b10:   parity_error = sum;
      default: parity_error = 1'b0;
    endcase
  endfunction

  // Synchronizer; all flops idle high so reset never looks like a start bit.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  always_ff @(posedge clk_in) begin
    if (reset_in) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Frame FSM state and per-frame configuration
  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;
  logic        dnum_q, dnum_d;
  logic [1:0]  par_q, par_d;
  logic        snum_q, snum_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        pbit_q, pbit_d;
  logic        stop_q, stop_d;
  logic        ferr_acc_q, ferr_acc_d;

  // Host-visible holding registers
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic [31:0] div_eff;
  logic        expire;
  logic        par_en;
  logic        frame_done;
  logic [7:0]  frame_data;
  logic        frame_perr;
  logic        frame_ferr;

  assign div_eff = (clk_div_baud_in < 32'd4) ? 32'd4 : clk_div_baud_in;
  assign expire  = (cnt_q == 32'd1);
  assign par_en  = (par_q == 2'b01) || (par_q == 2'b10);

  // In 7-bit mode only seven shifts happened, so the word sits in sh_q[7:1].
  assign frame_data = dnum_q ? {1'b0, sh_q[7:1]} : sh_q;
  assign frame_perr = parity_error(frame_data, pbit_q, par_q);
  assign frame_ferr = ferr_acc_q | ~rxs;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == S_IDLE) ? cnt_q : cnt_q - 32'd1;
    div_d      = div_q;
    dnum_d     = dnum_q;
    par_d      = par_q;
    snum_d     = snum_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    pbit_d     = pbit_q;
    stop_d     = stop_q;
    ferr_acc_d = ferr_acc_q;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_in && !rxs) begin
          state_d = S_START;
          cnt_d   = div_eff >> 1;
          div_d   = div_eff;
          dnum_d  = d_num_in;
          par_d   = parity_in;
          snum_d  = s_num_in;
        end
      end
      S_START: begin
        if (expire) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = div_q;
            bit_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (expire) begin
          sh_d  = {rxs, sh_q[7:1]};
          cnt_d = div_q;
          bit_d = bit_q + 3'd1;
          if (bit_q == (dnum_q ? 3'd6 : 3'd7)) begin
            state_d    = par_en ? S_PARITY : S_STOP;
            stop_d     = 1'b0;
            ferr_acc_d = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (expire) begin
          pbit_d  = rxs;
          cnt_d   = div_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (expire) begin
          if (snum_q && !stop_q) begin
            stop_d     = 1'b1;
            ferr_acc_d = ~rxs;
            cnt_d      = div_q;
          end else begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disabling aborts any frame in flight, including one about to complete.
    if (!enable_in) begin
      state_d    = S_IDLE;
      frame_done = 1'b0;
    end
  end

  always_comb begin
    data_d = data_q;
    rdy_d  = rdy_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (frame_done) begin
      // A read in the completion cycle frees the holding register in time.
      if (!rdy_q || rd_in) begin
        data_d = frame_data;
        perr_d = frame_perr;
        ferr_d = frame_ferr;
        rdy_d  = 1'b1;
        if (rd_in) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd_in) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame datapath: only meaningful while a frame is in progress.
  always_ff @(posedge clk_in) begin
    div_q      <= div_d;
    dnum_q     <= dnum_d;
    par_q      <= par_d;
    snum_q     <= snum_d;
    bit_q      <= bit_d;
    sh_q       <= sh_d;
    pbit_q     <= pbit_d;
    stop_q     <= stop_d;
    ferr_acc_q <= ferr_acc_d;
  end

  assign data_out       = data_q;
  assign rx_rdy_out     = rdy_q;
  assign parity_err_out = perr_q;
  assign frame_err_out  = ferr_q;
  assign overrun_out    = ovr_q;

endmodule

// File: tb/tb_uart_rx_control.sv
module tb_uart_rx_control;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        enable_in = 1'b0;
  logic        rx_in = 1'b1;
  logic [31:0] clk_div_baud_in = 32'd16;
  logic        d_num_in = 1'b0;
  logic [1:0]  parity_in = 2'b00;
  logic        s_num_in = 1'b0;
  logic        rd_in = 1'b0;
  logic [7:0]  data_out;
  logic        rx_rdy_out;
  logic        parity_err_out;
  logic        frame_err_out;
  logic        overrun_out;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_control #(.SYNC_STAGES(2)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .enable_in       (enable_in),
    .rx_in           (rx_in),
    .clk_div_baud_in (clk_div_baud_in),
    .d_num_in        (d_num_in),
    .parity_in       (parity_in),
    .s_num_in        (s_num_in),
    .rd_in           (rd_in),
    .data_out        (data_out),
    .rx_rdy_out      (rx_rdy_out),
    .parity_err_out  (parity_err_out),
    .frame_err_out   (frame_err_out),
    .overrun_out     (overrun_out)
  );

  always #10 clk_in = ~clk_in;

  initial begin
    #1800000;
    $display("FAIL watchdog: run still active at %0t, expected done", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic rd_pulse();
    rd_in = 1'b1;
    wait_cyc(1);
    rd_in = 1'b0;
  endtask

  // Drives one frame; entered and left 1 time unit after a rising edge.
  task automatic drive_frame(input logic [7:0] d, input int nbits, input int div,
                             input bit par_en, input logic pbit, input int nstop,
                             input logic stop_val);
    rx_in = 1'b0;
    wait_cyc(div);
    for (int i = 0; i < nbits; i++) begin
      rx_in = d[i];
      wait_cyc(div);
    end
    if (par_en) begin
      rx_in = pbit;
      wait_cyc(div);
    end
    for (int s = 0; s < nstop; s++) begin
      rx_in = stop_val;
      wait_cyc(div);
    end
    rx_in = 1'b1;
  endtask

  initial begin
    wait_cyc(3);
    reset_in = 1'b0;
    check("reset_data", data_out, 8'h00);
    check("reset_rdy", rx_rdy_out, 1'b0);
    check("reset_perr", parity_err_out, 1'b0);
    check("reset_ferr", frame_err_out, 1'b0);
    check("reset_ovr", overrun_out, 1'b0);

    enable_in = 1'b1;
    wait_cyc(4);

    // 8N1, DIV 16, 0x75: ready appears exactly 155 cycles after the line edge
    fork
      drive_frame(8'h75, 8, 16, 1'b0, 1'b0, 1, 1'b1);
      begin
        wait_cyc(154);
        check("t1_rdy_early", rx_rdy_out, 1'b0);
        wait_cyc(1);
        check("t1_rdy", rx_rdy_out, 1'b1);
        check("t1_data", data_out, 8'h75);
        check("t1_perr", parity_err_out, 1'b0);
        check("t1_ferr", frame_err_out, 1'b0);
        check("t1_ovr", overrun_out, 1'b0);
      end
    join
    wait_cyc(40);
    rd_pulse();
    check("t1_rd_clears", rx_rdy_out, 1'b0);
    check("t1_data_kept", data_out, 8'h75);

    // 7 bits, odd parity, 2 stop bits, 0x41 with good then bad parity bit
    d_num_in = 1'b1; parity_in = 2'b01; s_num_in = 1'b1;
    drive_frame(8'h41, 7, 16, 1'b1, 1'b1, 2, 1'b1);
    wait_cyc(40);
    check("t3_data", data_out, 8'h41);
    check("t3_rdy", rx_rdy_out, 1'b1);
    check("t3_perr_ok", parity_err_out, 1'b0);
    rd_pulse();
    drive_frame(8'h41, 7, 16, 1'b1, 1'b0, 2, 1'b1);
    wait_cyc(40);
    check("t3b_data", data_out, 8'h41);
    check("t3b_perr", parity_err_out, 1'b1);
    check("t3b_ferr", frame_err_out, 1'b0);
    rd_pulse();
    check("t3b_perr_clr", parity_err_out, 1'b0);

    // 8N1 0x55 with stop bit low
    d_num_in = 1'b0; parity_in = 2'b00; s_num_in = 1'b0;
    drive_frame(8'h55, 8, 16, 1'b0, 1'b0, 1, 1'b0);
    wait_cyc(60);
    check("t4_data", data_out, 8'h55);
    check("t4_ferr", frame_err_out, 1'b1);
    check("t4_perr", parity_err_out, 1'b0);
    check("t4_rdy", rx_rdy_out, 1'b1);
    rd_pulse();
    check("t4_ferr_clr", frame_err_out, 1'b0);

    // 4-cycle glitch is rejected as a false start
    rx_in = 1'b0;
    wait_cyc(4);
    rx_in = 1'b1;
    wait_cyc(60);
    check("glitch_rdy", rx_rdy_out, 1'b0);
    check("glitch_data", data_out, 8'h55);

    // Overrun: second frame dropped while first unread
    drive_frame(8'h11, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    wait_cyc(20);
    drive_frame(8'h22, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    wait_cyc(20);
    check("ovr_data", data_out, 8'h11);
    check("ovr_flag", overrun_out, 1'b1);
    check("ovr_rdy", rx_rdy_out, 1'b1);
    rd_pulse();
    check("ovr_clr", overrun_out, 1'b0);

    // Read strobe on the completion cycle of the second frame
    drive_frame(8'h11, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    wait_cyc(20);
    check("rdsame_first", data_out, 8'h11);
    fork
      drive_frame(8'h22, 8, 16, 1'b0, 1'b0, 1, 1'b1);
      begin
        wait_cyc(154);
        rd_in = 1'b1;
        wait_cyc(1);
        rd_in = 1'b0;
      end
    join
    wait_cyc(20);
    check("rdsame_data", data_out, 8'h22);
    check("rdsame_ovr", overrun_out, 1'b0);
    check("rdsame_rdy", rx_rdy_out, 1'b1);

    // Reset during data bit 3, then a clean 0xA5
    fork
      drive_frame(8'hA5, 8, 16, 1'b0, 1'b0, 1, 1'b1);
      begin
        wait_cyc(70);
        reset_in = 1'b1;
        wait_cyc(1);
        reset_in = 1'b0;
        check("rst_data", data_out, 8'h00);
        check("rst_rdy", rx_rdy_out, 1'b0);
        check("rst_ovr", overrun_out, 1'b0);
      end
    join
    wait_cyc(300);
    rd_pulse();
    wait_cyc(5);
    drive_frame(8'hA5, 8, 16, 1'b0, 1'b0, 1, 1'b1);
    wait_cyc(20);
    check("a5_data", data_out, 8'hA5);
    check("a5_rdy", rx_rdy_out, 1'b1);
    check("a5_ferr", frame_err_out, 1'b0);
    check("a5_ovr", overrun_out, 1'b0);
    rd_pulse();

    // Transmitter-rate frame: 0x75, 8N1, divisor 5208
    clk_div_baud_in = 32'd5208;
    drive_frame(8'h75, 8, 5208, 1'b0, 1'b0, 1, 1'b1);
    wait_cyc(20);
    check("lb_data", data_out, 8'h75);
    check("lb_rdy", rx_rdy_out, 1'b1);
    rd_pulse();
    check("lb_rd_clr", rx_rdy_out, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
